// File: rtl/usb_tx_data_buffer_if.sv
// Host/usb_tx side bundle of the TX data buffer: push port, pop port,
// control strobes and status outputs.
interface usb_tx_data_buffer_if #(
   parameter int ADDR_W = 6
);
   logic              store_tx_data;
   logic [7:0]        tx_data_in;
   logic              get_tx_packet;
   logic              flush;
   logic              clear_err;
   logic [7:0]        tx_packet_data;
   logic [ADDR_W:0]   buffer_occupancy;
   logic              full;
   logic              empty;
   logic              overflow_err;
   logic              underflow_err;

   // Producer/consumer side that drives the strobes and reads status.
   modport master (
      output store_tx_data, tx_data_in, get_tx_packet, flush, clear_err,
      input  tx_packet_data, buffer_occupancy, full, empty,
             overflow_err, underflow_err
   );

   // The buffer itself.
   modport slave (
      input  store_tx_data, tx_data_in, get_tx_packet, flush, clear_err,
      output tx_packet_data, buffer_occupancy, full, empty,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/usb_tx_data_buffer.sv
// 64-byte show-ahead FIFO feeding usb_tx with DATA-packet payload.
// The head byte is presented combinationally so usb_tx can load it in the
// same cycle it pops. Occupancy is kept in a separate counter so full and
// empty never depend on pointer comparison.
module usb_tx_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   usb_tx_data_buffer_if.slave    bus
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              mem_we;

   logic empty_w;
   logic full_w;
   logic pop_ok;
   logic push_ok;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == FULL_CNT);
   // A pop is only valid with data present; a push into a full buffer is
   // allowed when a valid pop frees the head slot in the same cycle.
   assign pop_ok  = bus.get_tx_packet && !empty_w;
   assign push_ok = bus.store_tx_data && (!full_w || pop_ok);

   // Next-state: flush overrides traffic; error set wins over clear_err.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;

      if (bus.clear_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_W + 1)'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_W + 1)'(1);
         end
         if (bus.store_tx_data && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (bus.get_tx_packet && !pop_ok) begin
            underflow_d = 1'b1;
         end
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Payload storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; its contents are never
      // observed while count says the slot is empty, and this keeps it a RAM.
      if (mem_we) begin
         mem_q[wr_ptr_q] <= bus.tx_data_in;
      end
   end

   assign bus.tx_packet_data   = empty_w ? 8'h00 : mem_q[rd_ptr_q];
   assign bus.buffer_occupancy = count_q;
   assign bus.full             = full_w;
   assign bus.empty            = empty_w;
   assign bus.overflow_err     = overflow_q;
   assign bus.underflow_err    = underflow_q;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Self-checking bench for usb_tx_data_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_usb_tx_data_buffer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   usb_tx_data_buffer_if #(.ADDR_W(6)) bus ();

   usb_tx_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a byte queue plus two sticky flags.
   logic [7:0] model_q[$];
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_step(input logic st, input logic [7:0] d, input logic g,
                             input logic fl, input logic ce);
      bit pop_ok, push_ok, ovf_set, udf_set;
      pop_ok = 0; push_ok = 0; ovf_set = 0; udf_set = 0;
      if (fl) begin
         model_q.delete();
      end else begin
         pop_ok  = g && (model_q.size() > 0);
         push_ok = st && ((model_q.size() < 64) || pop_ok);
         ovf_set = st && !push_ok;
         udf_set = g && (model_q.size() == 0);
         if (pop_ok)  void'(model_q.pop_front());
         if (push_ok) model_q.push_back(d);
      end
      m_ovf = ovf_set ? 1'b1 : (ce ? 1'b0 : m_ovf);
      m_udf = udf_set ? 1'b1 : (ce ? 1'b0 : m_udf);
   endtask

   task automatic check_all(input string tag);
      logic [7:0] head;
      head = (model_q.size() > 0) ? model_q[0] : 8'h00;
      check({tag, ".occ"},   32'(bus.buffer_occupancy), 32'(model_q.size()));
      check({tag, ".data"},  32'(bus.tx_packet_data), 32'(head));
      check({tag, ".full"},  32'(bus.full), 32'(model_q.size() == 64));
      check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
      check({tag, ".ovf"},   32'(bus.overflow_err), 32'(m_ovf));
      check({tag, ".udf"},   32'(bus.underflow_err), 32'(m_udf));
   endtask

   // One clock: drive strobes, clock edge, update model, sample at edge+1.
   task automatic do_cycle(input logic st, input logic [7:0] d, input logic g,
                           input logic fl, input logic ce);
      bus.store_tx_data = st;
      bus.tx_data_in    = d;
      bus.get_tx_packet = g;
      bus.flush         = fl;
      bus.clear_err     = ce;
      @(posedge clk);
      model_step(st, d, g, fl, ce);
      #1;
      bus.store_tx_data = 1'b0;
      bus.get_tx_packet = 1'b0;
      bus.flush         = 1'b0;
      bus.clear_err     = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      do_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] d;
      bus.store_tx_data = 1'b0;
      bus.tx_data_in    = 8'h00;
      bus.get_tx_packet = 1'b0;
      bus.flush         = 1'b0;
      bus.clear_err     = 1'b0;

      // Reset state.
      #12;
      check_all("reset");
      check("reset.empty_const", 32'(bus.empty), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic push/pop with show-ahead.
      push(8'hA5);
      push(8'h3C);
      check_all("two_push");
      check("two_push.head", 32'(bus.tx_packet_data), 32'hA5);
      check("two_push.occ", 32'(bus.buffer_occupancy), 32'd2);
      pop();
      check_all("pop1");
      check("pop1.head", 32'(bus.tx_packet_data), 32'h3C);
      pop();
      check_all("pop2");
      check("pop2.data0", 32'(bus.tx_packet_data), 32'h00);

      // Fill, overflow, drain in order.
      for (int i = 0; i < 64; i++) push(8'(i));
      check_all("fill");
      check("fill.full", 32'(bus.full), 32'd1);
      push(8'hFF);
      check_all("overflow");
      check("overflow.flag", 32'(bus.overflow_err), 32'd1);
      check("overflow.occ", 32'(bus.buffer_occupancy), 32'd64);
      for (int i = 0; i < 64; i++) begin
         check("drain.order", 32'(bus.tx_packet_data), 32'(i));
         pop();
      end
      check_all("drained");
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_all("clr_ovf");

      // Pointer wrap: 40 in / 40 out, three times.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 40; i++) push(8'($urandom));
         check_all("wrap.in");
         for (int i = 0; i < 40; i++) begin
            pop();
            check_all("wrap.out");
         end
      end
      check("wrap.final_occ", 32'(bus.buffer_occupancy), 32'd0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 64; i++) push(8'(i + 100));
      do_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      check_all("full_pp");
      check("full_pp.occ", 32'(bus.buffer_occupancy), 32'd64);
      check("full_pp.ovf", 32'(bus.overflow_err), 32'd0);
      for (int i = 0; i < 63; i++) pop();
      check_all("full_pp.tail");
      check("full_pp.head77", 32'(bus.tx_packet_data), 32'h77);
      pop();
      check_all("full_pp.empty");

      // Empty with simultaneous push and pop.
      do_cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      check_all("empty_pp");
      check("empty_pp.udf", 32'(bus.underflow_err), 32'd1);
      check("empty_pp.head", 32'(bus.tx_packet_data), 32'h11);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check_all("clr_udf");
      check("clr_udf.flag", 32'(bus.underflow_err), 32'd0);
      pop();
      // clear_err together with a new underflow: set wins.
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check_all("set_wins");
      check("set_wins.udf", 32'(bus.underflow_err), 32'd1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Flush with a push in the same cycle, then flush with a pop on empty.
      for (int i = 0; i < 10; i++) push(8'($urandom));
      check_all("pre_flush");
      do_cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      check_all("flush_push");
      check("flush_push.empty", 32'(bus.empty), 32'd1);
      do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check_all("flush_pop_empty");

      // Randomized traffic in push-heavy, balanced and pop-heavy phases.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 300; i++) begin
            logic st, g, fl, ce;
            st = ($urandom_range(99) < ((ph == 0) ? 85 : (ph == 1) ? 50 : 20));
            g  = ($urandom_range(99) < ((ph == 0) ? 20 : (ph == 1) ? 50 : 85));
            fl = ($urandom_range(99) < 2);
            ce = ($urandom_range(99) < 8);
            d  = 8'($urandom);
            do_cycle(st, d, g, fl, ce);
            check_all("rand");
         end
      end

      // Asynchronous reset mid-stream, with an error flag set beforehand.
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) push(8'(i + 8'h40));
      do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      pop();
      for (int i = 0; i < 3; i++) push(8'(i + 8'h50));
      check_all("pre_rst");
      #1;
      rst = 1'b1;
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #1;
      check_all("async_rst");
      check("async_rst.empty", 32'(bus.empty), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      push(8'hC3);
      check_all("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/usb_tx_data_buffer.md
Name: usb_tx_data_buffer

Overview:
- 64-byte FIFO directly upstream of usb_tx; holds the DATA-packet payload staged by the host-side interface.
- Host side pushes bytes with store_tx_data. usb_tx pops bytes with get_tx_packet and samples tx_packet_data.
- buffer_occupancy is wired to usb_tx tx_packet_data_size at the top level.
- Show-ahead read port: the head byte is always presented, so usb_tx loads its PTS register in the same cycle it pops.

Parameters:
DEPTH, 64, number of byte entries; must be a power of 2.
ADDR_W, 6, log2(DEPTH); pointer width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
store_tx_data  input  1  push strobe, one byte per cycle
tx_data_in  input  8  byte to push
get_tx_packet  input  1  pop strobe from usb_tx, one byte per cycle
flush  input  1  synchronous buffer clear
clear_err  input  1  clears sticky error flags
tx_packet_data  output  8  head byte (show-ahead); 8'h00 when empty
buffer_occupancy  output  7  stored byte count, 0..64
full  output  1  occupancy == 64
empty  output  1  occupancy == 0
overflow_err  output  1  sticky: push attempted while full
underflow_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst high, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, both error flags = 0. Outputs: tx_packet_data = 8'h00, buffer_occupancy = 0, full = 0, empty = 1. Storage array contents are don't-care and need no reset.
- Pointers are ADDR_W bits wide and wrap from 63 to 0 naturally. count is a separate 7-bit register; full and empty decode from count only.
- Read port is combinational from mem[rd_ptr], forced to 8'h00 when empty. Data is valid in the same cycle as get_tx_packet. rd_ptr advances at the clock edge.
- Push is accepted when store_tx_data = 1 and either (not full) or (full and a valid pop occurs in the same cycle).
  - Accepted push: mem[wr_ptr] <= tx_data_in; wr_ptr++.
- Pop is valid when get_tx_packet = 1 and not empty. Valid pop: rd_ptr++.
- count update: +1 for push only, -1 for pop only, unchanged when both occur.
- Empty with simultaneous push and pop: push is accepted, pop is rejected (no bypass), underflow_err sets, count becomes 1.
- Full with simultaneous push and pop: both are accepted, count stays 64, no overflow.
- Rejected push (full, no pop): data is dropped and overflow_err <= 1. Rejected pop (empty): pointers hold and underflow_err <= 1.
- Write-to-read latency: a byte pushed at edge N appears on tx_packet_data after edge N when it is the head entry (empty deasserts after edge N).
- flush has highest priority. At the next edge wr_ptr = rd_ptr = count = 0. Any push or pop in the same cycle is ignored and sets no error. Error flags are unaffected by flush.
- clear_err clears both flags at the next edge. If a new error event occurs in the same cycle, the set wins.
- Outputs are registered state or decodes of registered state. There is no combinational path from inputs to outputs except the read-address mux.

Test Plan:
- Reset, then push 8'hA5, 8'h3C -> occupancy = 2, tx_packet_data = 8'hA5. Pop -> 8'h3C shown next cycle, occupancy = 1. Pop -> empty = 1, data = 8'h00.
- Push 64 bytes 0x00..0x3F -> full = 1. Push 8'hFF -> overflow_err = 1 and occupancy stays 64. Pop all 64 -> data 0x00..0x3F in order (0xFF never appears).
- Push 40 and pop 40, three times -> pointer wrap exercised; output order always matches input order; final occupancy = 0.
- Full with simultaneous push 8'h77 and pop -> occupancy stays 64, no error. After 63 more pops the head is 8'h77.
- Empty with simultaneous push 8'h11 and pop -> underflow_err = 1, occupancy = 1, head = 8'h11. Then clear_err -> flag = 0.
- Occupancy 10 with flush plus push in the same cycle -> occupancy = 0, empty = 1, no error. Assert rst mid-stream -> all outputs take reset values immediately, without waiting for a clock edge.
